// File: rtl/ntt_writeback_ctrl_pkg.sv
// rtl/ntt_writeback_ctrl_pkg.sv - shared NTT constants, mode encodings and write-back FSM states
// Purpose: common definitions for ntt_core and its write-back controller.
// Contents: coefficient/address widths, stage mode encodings, FSM state type,
//           helper that selects the BRAM pairing for a stage mode.
package ntt_writeback_ctrl_pkg;

  localparam int DATA_W = 30;  // coefficient width produced by ntt_core
  localparam int ADDR_W = 9;   // BRAM word address width
  localparam int CNT_W  = 10;  // per-stage acceptance counter width

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // Modes 2 and 3 pair (r1,r2)/(r3,r4); modes 0 and 1 pair (r1,r3)/(r2,r4).
  function automatic logic pair_adjacent(input logic [1:0] m);
    return m >= MODE_2;
  endfunction

endpackage

// File: rtl/ntt_writeback_ctrl_if.sv
// rtl/ntt_writeback_ctrl_if.sv - read-issue/result and BRAM write bus of the write-back controller
// Purpose: bundles the ntt_core read/result signals and the two BRAM write ports.
// Modports: master - ntt_core/BRAM side (drives reads and results, receives writes)
//           slave  - write-back controller (receives reads and results, drives writes)
interface ntt_writeback_ctrl_if;
  import ntt_writeback_ctrl_pkg::*;

  logic                  rd_valid;
  logic [ADDR_W-1:0]     rd_address;
  logic [DATA_W-1:0]     r1;
  logic [DATA_W-1:0]     r2;
  logic [DATA_W-1:0]     r3;
  logic [DATA_W-1:0]     r4;
  logic                  upper_write_enable;
  logic                  lower_write_enable;
  logic [ADDR_W-1:0]     upper_write_address;
  logic [ADDR_W-1:0]     lower_write_address;
  logic [2*DATA_W-1:0]   upper_data_input;
  logic [2*DATA_W-1:0]   lower_data_input;

  modport master (
    output rd_valid, rd_address, r1, r2, r3, r4,
    input  upper_write_enable, lower_write_enable,
    input  upper_write_address, lower_write_address,
    input  upper_data_input, lower_data_input
  );

  modport slave (
    input  rd_valid, rd_address, r1, r2, r3, r4,
    output upper_write_enable, lower_write_enable,
    output upper_write_address, lower_write_address,
    output upper_data_input, lower_data_input
  );

endinterface

// File: rtl/ntt_addr_delay.sv
// rtl/ntt_addr_delay.sv - DEPTH-deep valid/address delay line with synchronous clear
// Purpose: carries each accepted read address alongside the ntt_core pipeline.
// Ports: clk, rst (sync, active-high clear of all stages)
//        entry_valid/entry_addr - new entry this cycle
//        tap_valid/tap_addr     - entry that entered DEPTH cycles ago
//        pending                - any stage holds a valid entry
module ntt_addr_delay #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_valid,
  input  logic [WIDTH-1:0] entry_addr,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_addr,
  output logic             pending
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= entry_valid;
      addr_q[0]  <= entry_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign tap_valid = valid_q[DEPTH-1];
  assign tap_addr  = addr_q[DEPTH-1];
  assign pending   = |valid_q;

endmodule

// File: rtl/ntt_writeback_ctrl.sv
// rtl/ntt_writeback_ctrl.sv - collects ntt_core butterfly results and writes them back to BRAM
// Purpose: per NTT stage, tracks WORDS issued reads, delays each address by LATENCY
//          cycles and writes the paired results to the upper/lower BRAMs.
// Ports: clk, rst (sync, active-high); start/mode arm one stage; bus (slave) carries
//        rd_valid/rd_address/r1..r4 in and the two BRAM write ports out;
//        busy high in RUN/DRAIN; done pulses once per completed stage.
module ntt_writeback_ctrl
  import ntt_writeback_ctrl_pkg::*;
#(
  parameter int LATENCY   = 8,
  parameter int WORDS     = 512,
  parameter int MOD_INDEX = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  ntt_writeback_ctrl_if.slave  bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WORDS);

  // The modulus selector only distinguishes instances; no logic depends on it.
  if (MOD_INDEX < 0) begin : g_mod_index_unused
  end

  wb_state_e              state_q, state_d;
  logic [CNT_W-1:0]       accept_cnt;
  logic [1:0]             mode_q;
  logic                   accept, arm;
  logic                   tap_valid, pending;
  logic [ADDR_W-1:0]      tap_addr;
  logic                   write_en_q;
  logic [ADDR_W-1:0]      write_addr_q;
  logic [2*DATA_W-1:0]    upper_q, lower_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    arm     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          arm     = 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (bus.rd_valid) begin
          accept = 1'b1;
          if (accept_cnt == LAST_COUNT) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Once the line is empty the last entry's write is on the bus this cycle.
        if (!pending) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt <= '0;
      mode_q     <= MODE_0;
    end else if (arm) begin
      accept_cnt <= '0;
      mode_q     <= mode;
    end else if (accept && accept_cnt != FULL_COUNT) begin
      accept_cnt <= accept_cnt + 1'b1;
    end
  end

  ntt_addr_delay #(
    .DEPTH (LATENCY),
    .WIDTH (ADDR_W)
  ) u_addr_delay (
    .clk         (clk),
    .rst         (rst),
    .entry_valid (accept),
    .entry_addr  (bus.rd_address),
    .tap_valid   (tap_valid),
    .tap_addr    (tap_addr),
    .pending     (pending)
  );

  // r1..r4 belong to the entry emerging this cycle; address and data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      upper_q      <= '0;
      lower_q      <= '0;
    end else begin
      write_en_q <= tap_valid;
      if (tap_valid) begin
        write_addr_q <= tap_addr;
        if (pair_adjacent(mode_q)) begin
          upper_q <= {bus.r2, bus.r1};
          lower_q <= {bus.r4, bus.r3};
        end else begin
          upper_q <= {bus.r3, bus.r1};
          lower_q <= {bus.r4, bus.r2};
        end
      end
    end
  end

  assign bus.upper_write_enable  = write_en_q;
  assign bus.lower_write_enable  = write_en_q;
  assign bus.upper_write_address = write_addr_q;
  assign bus.lower_write_address = write_addr_q;
  assign bus.upper_data_input    = upper_q;
  assign bus.lower_data_input    = lower_q;

endmodule

// File: tb/tb_ntt_writeback_ctrl.sv
// tb/tb_ntt_writeback_ctrl.sv - directed self-checking bench for ntt_writeback_ctrl
module tb_ntt_writeback_ctrl;
  import ntt_writeback_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    logic [8:0]  addr;
    logic [59:0] up;
    logic [59:0] lo;
    logic        paired;
  } wr_t;

  localparam logic [59:0] UP_M0 = {30'd3, 30'd1};
  localparam logic [59:0] LO_M0 = {30'd4, 30'd2};
  localparam logic [59:0] UP_M2 = {30'd2, 30'd1};
  localparam logic [59:0] LO_M2 = {30'd4, 30'd3};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic       r_fixed = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  wr_t        wr_q[$];
  int         done_q[$];
  logic [8:0] alt_addr [3] = '{9'd10, 9'd20, 9'd30};

  ntt_writeback_ctrl_if bus ();

  ntt_writeback_ctrl #(
    .LATENCY   (8),
    .WORDS     (512),
    .MOD_INDEX (0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] rv(int c, int k);
    return 30'(c * 8 + k);
  endfunction

  function automatic wr_t wr_at(int i);
    wr_t w;
    w.cyc = -1; w.addr = '1; w.up = '1; w.lo = '1; w.paired = 1'b0;
    if (i < wr_q.size()) w = wr_q[i];
    return w;
  endfunction

  // Advance one cycle, sample outputs 1 time unit after the edge, then drive r1..r4.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.upper_write_enable || bus.lower_write_enable) begin
      w.cyc    = cyc;
      w.addr   = bus.upper_write_address;
      w.up     = bus.upper_data_input;
      w.lo     = bus.lower_data_input;
      w.paired = bus.upper_write_enable && bus.lower_write_enable &&
                 (bus.upper_write_address == bus.lower_write_address);
      wr_q.push_back(w);
    end
    if (done) done_q.push_back(cyc);
    if (!r_fixed) begin
      bus.r1 = rv(cyc, 1); bus.r2 = rv(cyc, 2);
      bus.r3 = rv(cyc, 3); bus.r4 = rv(cyc, 4);
    end
  endtask

  task automatic clear_log();
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
  endtask

  task automatic set_r_fixed();
    r_fixed = 1'b1;
    bus.r1 = 30'd1; bus.r2 = 30'd2; bus.r3 = 30'd3; bus.r4 = 30'd4;
  endtask

  task automatic run_stage(logic [1:0] m, logic start_last, logic [1:0] m_last, output int c0);
    clear_log();
    start = 1'b1; mode = m; tick(); start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 512; i++) begin
      bus.rd_valid = 1'b1; bus.rd_address = 9'(i);
      if (i == 511 && start_last) begin start = 1'b1; mode = m_last; end
      tick();
    end
    bus.rd_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    while (done_q.size() == 0 && n < budget) begin tick(); n++; end
    check_eq({tag, "_done_seen"}, done_q.size() > 0, 1);
  endtask

  task automatic check_stage(string tag, logic [59:0] eu, logic [59:0] el, int c0);
    int bad = 0;
    int dcyc = -1;
    wr_t f;
    foreach (wr_q[i])
      if (wr_q[i].addr != 9'(i) || wr_q[i].cyc != c0 + 9 + i || !wr_q[i].paired ||
          wr_q[i].up != eu || wr_q[i].lo != el) bad++;
    if (done_q.size() > 0) dcyc = done_q[0] - c0;
    f = wr_at(0);
    check_eq({tag, "_writes"}, wr_q.size(), 512);
    check_eq({tag, "_first_lat"}, f.cyc - c0, 9);
    check_eq({tag, "_first_addr"}, f.addr, 0);
    check_eq({tag, "_first_up"}, f.up, eu);
    check_eq({tag, "_first_lo"}, f.lo, el);
    check_eq({tag, "_last_addr"}, wr_at(511).addr, 511);
    check_eq({tag, "_seq_bad"}, bad, 0);
    check_eq({tag, "_done_cnt"}, done_q.size(), 1);
    check_eq({tag, "_done_cyc"}, dcyc, 521);
    check_eq({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int c0, late, n_before, busy_hi;
    wr_t w;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    bus.rd_valid = 1'b0; bus.rd_address = '0;
    set_r_fixed();

    // Reset values
    tick(); tick();
    check_eq("rst_we", {bus.upper_write_enable, bus.lower_write_enable}, 0);
    check_eq("rst_addr", {bus.upper_write_address, bus.lower_write_address}, 0);
    check_eq("rst_up", bus.upper_data_input, 0);
    check_eq("rst_lo", bus.lower_data_input, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0; tick();

    // Full stage, mode 0
    run_stage(2'd0, 1'b0, 2'd0, c0);
    check_eq("m0_busy_drain", busy, 1);
    wait_done("m0", 40);
    repeat (3) tick();
    check_stage("m0", UP_M0, LO_M0, c0);

    // Full stage, mode 2
    run_stage(2'd2, 1'b0, 2'd0, c0);
    wait_done("m2", 40);
    repeat (3) tick();
    check_stage("m2", UP_M2, LO_M2, c0);

    // Alternate-cycle reads with results changing every cycle
    clear_log();
    r_fixed = 1'b0;
    start = 1'b1; mode = 2'd0; tick(); start = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      bus.rd_valid = 1'b1; bus.rd_address = alt_addr[k]; tick();
      bus.rd_valid = 1'b0; tick();
    end
    repeat (12) tick();
    check_eq("alt_writes", wr_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      w = wr_at(k);
      check_eq($sformatf("alt%0d_addr", k), w.addr, alt_addr[k]);
      check_eq($sformatf("alt%0d_cyc", k), w.cyc - c0, 9 + 2 * k);
      check_eq($sformatf("alt%0d_up", k), w.up, {rv(c0 + 2 * k + 8, 3), rv(c0 + 2 * k + 8, 1)});
      check_eq($sformatf("alt%0d_lo", k), w.lo, {rv(c0 + 2 * k + 8, 4), rv(c0 + 2 * k + 8, 2)});
    end
    set_r_fixed();
    do_reset();

    // Mode 3 uses the mode 2 pairing
    clear_log();
    start = 1'b1; mode = 2'd3; tick(); start = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_address = 9'd77; tick(); bus.rd_valid = 1'b0;
    repeat (12) tick();
    check_eq("m3_writes", wr_q.size(), 1);
    check_eq("m3_addr", wr_at(0).addr, 77);
    check_eq("m3_up", wr_at(0).up, UP_M2);
    check_eq("m3_lo", wr_at(0).lo, LO_M2);
    do_reset();

    // Reset after 100 acceptances, with start and rd_valid on the reset cycle
    clear_log();
    start = 1'b1; mode = 2'd0; tick(); start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      bus.rd_valid = 1'b1; bus.rd_address = 9'(i); tick();
    end
    rst = 1'b1; start = 1'b1; mode = 2'd2; bus.rd_address = 9'd100; tick();
    rst = 1'b0; start = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    tick(); tick();
    bus.rd_valid = 1'b0;
    repeat (15) tick();
    late = 0;
    foreach (wr_q[i]) if (wr_q[i].cyc > c0 + 100) late++;
    check_eq("mid_rst_late_writes", late, 0);
    check_eq("mid_rst_writes", wr_q.size(), 92);
    check_eq("mid_rst_done", done_q.size(), 0);
    check_eq("mid_rst_busy_end", busy, 0);

    run_stage(2'd0, 1'b0, 2'd0, c0);
    wait_done("post_rst", 40);
    repeat (3) tick();
    check_stage("post_rst", UP_M0, LO_M0, c0);

    // rd_valid in IDLE ignored; start during RUN does not change the latched mode
    clear_log();
    bus.rd_valid = 1'b1; bus.rd_address = 9'd5; tick();
    bus.rd_valid = 1'b0; tick();
    bus.rd_valid = 1'b1; bus.rd_address = 9'd6; tick();
    bus.rd_valid = 1'b0; tick();
    start = 1'b1; mode = 2'd0; tick(); start = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_address = 9'd100; tick();
    bus.rd_valid = 1'b0;
    start = 1'b1; mode = 2'd2; tick(); start = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_address = 9'd101; tick();
    bus.rd_valid = 1'b0;
    repeat (12) tick();
    check_eq("idle_rd_writes", wr_q.size(), 2);
    check_eq("idle_rd_addr0", wr_at(0).addr, 100);
    check_eq("idle_rd_addr1", wr_at(1).addr, 101);
    check_eq("idle_rd_up1", wr_at(1).up, UP_M0);
    check_eq("idle_rd_lo1", wr_at(1).lo, LO_M0);
    do_reset();

    // Last acceptance coincident with start
    run_stage(2'd0, 1'b1, 2'd2, c0);
    wait_done("coinc", 40);
    repeat (3) tick();
    check_stage("coinc", UP_M0, LO_M0, c0);
    n_before = wr_q.size();
    busy_hi = 0;
    for (int i = 0; i < 5; i++) begin
      bus.rd_valid = 1'b1; bus.rd_address = 9'(200 + i); tick();
      busy_hi += int'(busy);
    end
    bus.rd_valid = 1'b0;
    repeat (12) begin tick(); busy_hi += int'(busy); end
    check_eq("coinc_no_extra_writes", wr_q.size() - n_before, 0);
    check_eq("coinc_busy_after", busy_hi, 0);
    check_eq("coinc_done_total", done_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_writeback_ctrl.md
NTT_WRITEBACK_CTRL -- requirements
Module: ntt_writeback_ctrl

Interface
REQ-001 Parameter LATENCY, default 8: cycles from rd_valid/rd_address presentation to valid r1..r4 at the ntt_core outputs.
REQ-002 Parameter WORDS, default 512: read addresses issued per stage.
REQ-003 Parameter MOD_INDEX, default 0: modulus selector; carried for instance matching only, no functional effect.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that arms collection of one NTT stage.
REQ-007 mode  input  2  stage mode, same encoding as ntt_core; sampled on the accepted start.
REQ-008 rd_valid  input  1  a read was issued to ntt_core this cycle.
REQ-009 rd_address  input  9  read address issued with rd_valid.
REQ-010 r1, r2, r3, r4  input  30 each  butterfly results from ntt_core.
REQ-011 upper_write_enable, lower_write_enable  output  1 each  BRAM write strobes.
REQ-012 upper_write_address, lower_write_address  output  9 each  BRAM write addresses.
REQ-013 upper_data_input, lower_data_input  output  60 each  BRAM write data.
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  one-cycle pulse when the last write of a stage has been issued.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE: start -> RUN, latch mode, clear accept counter; otherwise stay.
REQ-018 RUN: each rd_valid increments the accept counter and enters a LATENCY-deep valid/address delay line; on acceptance number WORDS -> DRAIN.
REQ-019 DRAIN: no new entries; when the delay line holds no valid entry and the last write is issued -> DONE.
REQ-020 DONE: done=1 for exactly one cycle -> IDLE.
REQ-021 rd_valid outside RUN is ignored (no delay-line entry, no write).
REQ-022 start outside IDLE is ignored; latched mode unchanged.
REQ-023 A delay-line entry emerging after LATENCY cycles asserts both write enables for one cycle, registered, so writes appear LATENCY+1 cycles after the rd_valid.
REQ-024 Both write addresses equal the delayed rd_address.
REQ-025 Latched mode 0 or 1: upper_data_input = {r3, r1}, lower_data_input = {r4, r2} (first-named operand in bits 59:30).
REQ-026 Latched mode 2: upper_data_input = {r2, r1}, lower_data_input = {r4, r3}.
REQ-027 Latched mode 3: treated as mode 2.
REQ-028 Write strobes and data are registered; r1..r4 are sampled on the cycle the entry emerges.
REQ-029 Back-to-back rd_valid every cycle sustains one write pair per cycle, no bubbles.
REQ-030 Accept counter is 10 bits and does not wrap within a stage; counting saturates at WORDS.
REQ-031 Last acceptance and start on the same cycle: start ignored.
REQ-032 Write data and addresses hold their last values while enables are low.

Reset
REQ-033 rst forces the FSM to IDLE and clears the accept counter and all delay-line valid bits, also mid-stage, so no write enable is asserted from the cycle after rst onward.
REQ-034 Reset values: write enables 0, write addresses 0, data inputs 0, busy 0, done 0.
REQ-035 rst takes priority over start and rd_valid on the same cycle.

Structure
REQ-036 FSM state encoding and the mode encodings (0,1,2) live in the shared NTT package alongside the constants already used by ntt_core.
REQ-037 The LATENCY-deep valid/address delay line is one sub-module, ntt_addr_delay (parameters DEPTH, WIDTH; synchronous clear on rst).

Verification
REQ-038 start with mode=0, then 512 consecutive rd_valid with rd_address 0..511, r1..r4 = 1,2,3,4 -> first write pair at cycle 9 after the first rd_valid, upper data {3,1}, lower data {4,2}, address 0; 512 consecutive write pairs; done one cycle after the write to address 511.
REQ-039 Same run with mode=2 -> upper data {2,1}, lower data {4,3} on every write.
REQ-040 rd_valid on alternate cycles, addresses 10,20,30 -> writes at addresses 10,20,30, each 9 cycles after its rd_valid, enables low in between.
REQ-041 rst asserted after 100 acceptances -> no write enable from the next cycle on, busy=0, done never pulses; a following start/512-read stage completes normally.
REQ-042 rd_valid pulses in IDLE, then start during RUN with a different mode -> no writes from the IDLE pulses; latched mode unchanged.
REQ-043 Last (512th) rd_valid coincident with start -> start ignored, FSM passes DRAIN, DONE, IDLE; busy low afterwards.
